fifo_sched: RTL and testbench

FIFO_SCHED -- requirements
Module: fifo_sched

---
 rtl/fifo_sched_pkg.sv | 26 ++
 rtl/fifo_sched_fsm.sv | 59 +++++
 rtl/fifo_sched.sv | 111 +++++++++++
 tb/tb_fifo_sched.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: shared parameters and types for the FIFO bank scheduler.
//   A_W        - default FIFO pointer width (DEPTH = 2**A_W)
//   flush_st_e - flush sequencer state encoding
//   cnt_step() - occupancy update for one cycle of grants
package fifo_sched_pkg;

  localparam int unsigned A_W = 3;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StFlWait = 2'd1,
    StFlClr  = 2'd2
  } flush_st_e;

  // Occupancy after one cycle: a simultaneous read and write cancel out.
  function automatic logic [A_W:0] cnt_step_default(input logic [A_W:0] cnt,
                                                    input logic       wr,
                                                    input logic       rd);
    logic [A_W:0] res;
    res = cnt;
    if (wr && !rd) res = cnt + (A_W + 1)'(1);
    if (rd && !wr) res = cnt - (A_W + 1)'(1);
    return res;
  endfunction

endpackage

// File: rtl/fifo_sched_fsm.sv
// fifo_sched_fsm: flush sequencer RUN -> FL_WAIT -> FL_CLR -> RUN.
//   clk_i, rst_i    - clock, asynchronous active-high reset
//   en_i            - global enable; low holds the state
//   flush_req_i     - flush request, sampled in RUN
//   st_run_o        - sequencer is in RUN (grants allowed)
//   st_clr_o        - sequencer is in FL_CLR (pointers/count clear at end)
//   flush_busy_o    - registered, high in FL_WAIT and FL_CLR
//   fifo_flush_o    - registered, high only in FL_CLR
module fifo_sched_fsm
  import fifo_sched_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic flush_req_i,
  output logic st_run_o,
  output logic st_clr_o,
  output logic flush_busy_o,
  output logic fifo_flush_o
);

  flush_st_e state_q, state_d;
  logic      busy_q, busy_d;
  logic      flush_q, flush_d;

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      unique case (state_q)
        StRun:    if (flush_req_i) state_d = StFlWait;
        // One idle cycle lets an outstanding rd_vld retire before the clear.
        StFlWait: state_d = StFlClr;
        StFlClr:  state_d = StRun;
        default:  state_d = StRun;
      endcase
    end
    // Outputs are decoded from the next state so they are registered.
    busy_d  = (state_d != StRun);
    flush_d = (state_d == StFlClr);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
      busy_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      flush_q <= flush_d;
    end
  end

  assign st_run_o     = (state_q == StRun);
  assign st_clr_o     = (state_q == StFlClr);
  assign flush_busy_o = busy_q;
  assign fifo_flush_o = flush_q;

endmodule

// File: rtl/fifo_sched.sv
// fifo_sched: grant scheduler for a FIFO stored in two single-port banks
// (even/odd entries). Arbitrates producer writes against consumer reads,
// tracks occupancy and sequences a flush.
//   clk, rst             - clock, asynchronous active-high reset
//   en                   - global enable; low freezes state and grants
//   wr_req / wr_gnt      - producer request / write accepted this cycle
//   rd_req / rd_gnt      - consumer request / read accepted this cycle
//   rd_vld               - bank read data valid, one cycle after rd_gnt
//   flush_req/flush_busy - discard contents / flush sequence in progress
//   full, empty, count   - occupancy
//   fifo_en/we/re/flush  - direct drive of the FIFO's control inputs
module fifo_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = A_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wr_req,
  output logic            wr_gnt,
  input  logic            rd_req,
  output logic            rd_gnt,
  output logic            rd_vld,
  input  logic            flush_req,
  output logic            flush_busy,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            fifo_en,
  output logic            fifo_we,
  output logic            fifo_re,
  output logic            fifo_flush
);

  localparam int unsigned    DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);

  logic [ADDR_W:0] count_q, count_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic            rd_vld_q, rd_vld_d;
  logic            st_run, st_clr;
  logic            bank_conflict;

  fifo_sched_fsm u_fsm (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .flush_req_i  (flush_req),
    .st_run_o     (st_run),
    .st_clr_o     (st_clr),
    .flush_busy_o (flush_busy),
    .fifo_flush_o (fifo_flush)
  );

  // Flags decode only registered count, so requests never reach them.
  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  // rst gating keeps grants low while reset is held, even with requests up.
  assign rd_gnt = !rst && en && st_run && rd_req && !empty && !flush_req;

  // Both ports hitting the same bank: the read wins, the write retries next
  // cycle when the read has flipped the bank parity.
  assign bank_conflict = rd_gnt && (wr_bank_q == rd_bank_q);
  assign wr_gnt = !rst && en && st_run && wr_req && !full && !flush_req && !bank_conflict;

  always_comb begin
    count_d   = count_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_vld_d  = rd_vld_q;
    if (en) begin
      if (st_clr) begin
        count_d   = '0;
        wr_bank_d = 1'b0;
        rd_bank_d = 1'b0;
        rd_vld_d  = 1'b0;
      end else begin
        if (wr_gnt && !rd_gnt) count_d = count_q + CntOne;
        if (rd_gnt && !wr_gnt) count_d = count_q - CntOne;
        wr_bank_d = wr_bank_q ^ wr_gnt;
        rd_bank_d = rd_bank_q ^ rd_gnt;
        rd_vld_d  = rd_gnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign count   = count_q;
  assign rd_vld  = rd_vld_q;
  assign fifo_en = en;
  assign fifo_we = wr_gnt;
  assign fifo_re = rd_gnt;

endmodule

// File: tb/tb_fifo_sched.sv
// tb_fifo_sched: directed, table-driven bench for fifo_sched (DEPTH = 8),
// plus hand-written reset sequences.
module tb_fifo_sched;

  localparam int unsigned ADDR_W = 3;
  localparam int          DEPTH  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            en, wr_req, rd_req, flush_req;
  logic            wr_gnt, rd_gnt, rd_vld, flush_busy, full, empty;
  logic [ADDR_W:0] count;
  logic            fifo_en, fifo_we, fifo_re, fifo_flush;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_sched #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_req     (wr_req),
    .wr_gnt     (wr_gnt),
    .rd_req     (rd_req),
    .rd_gnt     (rd_gnt),
    .rd_vld     (rd_vld),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .fifo_en    (fifo_en),
    .fifo_we    (fifo_we),
    .fifo_re    (fifo_re),
    .fifo_flush (fifo_flush)
  );

  typedef struct {
    logic en, wr, rd, fl;      // inputs for the cycle
    logic wg, rg;              // grants expected during the cycle
    int   cnt;                 // count expected after the edge
    logic busy, ffl, vld;      // registered outputs expected after the edge
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic e, input logic w, input logic r, input logic f,
                     input logic wg, input logic rg, input int c,
                     input logic b, input logic ff, input logic v);
    vec_t t;
    t = '{en: e, wr: w, rd: r, fl: f, wg: wg, rg: rg, cnt: c, busy: b, ffl: ff, vld: v};
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int seen_flush;
  always @(posedge clk or negedge clk) if (fifo_flush === 1'b1) seen_flush++;

  initial begin
    //   en wr rd fl  wg rg  cnt busy ffl vld
    add(1, 1, 0, 0,  1, 0,  1,  0,  0,  0);  // 3 writes alone
    add(1, 1, 0, 0,  1, 0,  2,  0,  0,  0);
    add(1, 1, 0, 0,  1, 0,  3,  0,  0,  0);
    add(1, 1, 1, 0,  1, 1,  3,  0,  0,  1);  // odd count: banks differ, both go
    add(1, 0, 1, 0,  0, 1,  2,  0,  0,  1);
    add(1, 1, 1, 0,  0, 1,  1,  0,  0,  1);  // even count: read wins conflict
    add(1, 1, 0, 0,  1, 0,  2,  0,  0,  0);  // stalled write granted next cycle
    add(0, 1, 1, 0,  0, 0,  2,  0,  0,  0);  // en low freezes
    add(1, 1, 0, 0,  1, 0,  3,  0,  0,  0);  // fill
    add(1, 1, 0, 0,  1, 0,  4,  0,  0,  0);
    add(1, 1, 0, 0,  1, 0,  5,  0,  0,  0);
    add(1, 1, 0, 0,  1, 0,  6,  0,  0,  0);
    add(1, 1, 0, 0,  1, 0,  7,  0,  0,  0);
    add(1, 1, 0, 0,  1, 0,  8,  0,  0,  0);
    add(1, 1, 0, 0,  0, 0,  8,  0,  0,  0);  // full refuses write
    add(1, 1, 1, 0,  0, 1,  7,  0,  0,  1);  // full with both: read only
    add(1, 0, 1, 0,  0, 1,  6,  0,  0,  1);
    add(1, 0, 1, 0,  0, 1,  5,  0,  0,  1);
    add(1, 1, 1, 1,  0, 0,  5,  1,  0,  0);  // flush sampled, blocks grants
    add(1, 1, 1, 0,  0, 0,  5,  1,  1,  0);  // FL_WAIT
    add(1, 1, 1, 0,  0, 0,  0,  0,  0,  0);  // FL_CLR, clears at end
    add(1, 1, 1, 0,  1, 0,  1,  0,  0,  0);  // empty with both: write only
    add(1, 0, 0, 1,  0, 0,  1,  1,  0,  0);  // flush with en gaps
    add(0, 0, 0, 0,  0, 0,  1,  1,  0,  0);
    add(1, 0, 0, 0,  0, 0,  1,  1,  1,  0);
    add(0, 0, 0, 0,  0, 0,  1,  1,  1,  0);
    add(1, 0, 0, 0,  0, 0,  0,  0,  0,  0);

    // Reset with requests up: no grants, reset values.
    rst = 1'b1; en = 1'b1; wr_req = 1'b1; rd_req = 1'b1; flush_req = 1'b0;
    @(negedge clk); #2;
    chk("rst wr_gnt", wr_gnt, 0);
    chk("rst rd_gnt", rd_gnt, 0);
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst flush_busy", flush_busy, 0);
    chk("rst fifo_flush", fifo_flush, 0);
    chk("rst rd_vld", rd_vld, 0);
    @(negedge clk);
    rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      en = vq[i].en; wr_req = vq[i].wr; rd_req = vq[i].rd; flush_req = vq[i].fl;
      #2;
      chk($sformatf("v%0d wr_gnt", i), wr_gnt, vq[i].wg);
      chk($sformatf("v%0d rd_gnt", i), rd_gnt, vq[i].rg);
      chk($sformatf("v%0d fifo_we", i), fifo_we, vq[i].wg);
      chk($sformatf("v%0d fifo_re", i), fifo_re, vq[i].rg);
      chk($sformatf("v%0d fifo_en", i), fifo_en, vq[i].en);
      @(posedge clk); #1;
      chk($sformatf("v%0d count", i), count, vq[i].cnt);
      chk($sformatf("v%0d empty", i), empty, vq[i].cnt == 0);
      chk($sformatf("v%0d full", i), full, vq[i].cnt == DEPTH);
      chk($sformatf("v%0d flush_busy", i), flush_busy, vq[i].busy);
      chk($sformatf("v%0d fifo_flush", i), fifo_flush, vq[i].ffl);
      chk($sformatf("v%0d rd_vld", i), rd_vld, vq[i].vld);
    end

    // Reset during FL_WAIT abandons the flush with no pulse.
    @(negedge clk);
    en = 1'b1; wr_req = 1'b1; rd_req = 1'b0; flush_req = 1'b0;
    repeat (2) @(negedge clk);
    wr_req = 1'b0; flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    #1;
    chk("pre-rst count", count, 2);
    chk("pre-rst flush_busy", flush_busy, 1);
    seen_flush = 0;
    wr_req = 1'b1;
    rst = 1'b1;
    #1;
    chk("midflush rst count", count, 0);
    chk("midflush rst empty", empty, 1);
    chk("midflush rst flush_busy", flush_busy, 0);
    chk("midflush rst fifo_flush", fifo_flush, 0);
    chk("midflush rst wr_gnt", wr_gnt, 0);
    @(negedge clk);
    rst = 1'b0; wr_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("no flush pulse after rst", seen_flush, 0);
    wr_req = 1'b1;
    #2;
    chk("post-rst RUN wr_gnt", wr_gnt, 1);
    @(posedge clk); #1;
    chk("post-rst count", count, 1);
    chk("post-rst empty", empty, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
